// File: rtl/series_pkg.sv
// rtl/series_pkg.sv - shared types and Q1.15 constants for the series evaluator
// Purpose : FSM state encoding and fixed-point constants used by
//           series_eval_ctrl and q15_mul.
// Ports   : none (package)
package series_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    TERM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          Q_FRAC = 15;
  localparam logic [15:0] Q_MAX  = 16'h7FFF;
  localparam logic [15:0] Q_MIN  = 16'h8000;
  localparam int          ADDR_W = 3;

endpackage

// File: rtl/q15_mul.sv
// rtl/q15_mul.sv - combinational signed Q1.15 multiply with saturation
// Purpose : p = a * b in Q1.15. The full 32-bit product is scaled down by
//           Q_FRAC bits (truncated, or rounded half-up when ROUND_EN is
//           defined) and clamped to [Q_MIN, Q_MAX].
// Config  : ROUND_EN - add 2^14 before scaling (round to nearest).
// Ports   : a  in  16  signed Q1.15 operand
//           b  in  16  signed Q1.15 operand
//           p  out 16  signed Q1.15 saturated product
module q15_mul
  import series_pkg::*;
(
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] p
);

  logic signed [31:0] prod;

  always_comb begin
    prod = 32'(a) * 32'(b);
`ifdef ROUND_EN
    prod = prod + 32'sd16384;
`else
    prod = prod + 32'sd0;
`endif
    // Only -1 * -1 can exceed the Q1.15 range (+1.0); the lower bound is kept for symmetry.
    if (prod >= 32'sh4000_0000) begin
      p = Q_MAX;
    end else if (prod < -32'sh4000_0000) begin
      p = Q_MIN;
    end else begin
      p = prod[Q_FRAC+15:Q_FRAC];
    end
  end

endmodule

// File: rtl/series_eval_ctrl.sv
// rtl/series_eval_ctrl.sv - sequences the coefficient ROM to evaluate a power series
// Purpose : y = sum_{k=0}^{TERMS-1} c[k] * x^(k+1), signed Q1.15, saturated.
// Config  : ROUND_EN (in q15_mul) selects rounding instead of truncation.
// Ports   : clk       in   1   clock
//           rst       in   1   synchronous active-high reset
//           start     in   1   request, sampled only in IDLE
//           x_in      in   16  operand x (Q1.15), captured with start
//           rom_data  in   16  coefficient c[rom_addr] (combinational ROM)
//           rom_addr  out  3   ROM address
//           busy      out  1   evaluation in progress
//           done      out  1   one-cycle completion pulse
//           result    out  16  saturated y, held until the next done
module series_eval_ctrl
  import series_pkg::*;
#(
  parameter int TERMS = 8,
  parameter int ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       x_in,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TERMS - 1);

  state_t                    state, state_nxt;
  logic signed [15:0]        x_q, pow, pow_nxt, term;
  logic signed [ACC_W-1:0]   acc, acc_sum;
  logic [ACC_W-16:0]         acc_top;
  logic [15:0]               result_nxt;
  logic                      last;

  q15_mul u_term (.a(rom_data), .b(pow), .p(term));
  q15_mul u_pow  (.a(pow),      .b(x_q), .p(pow_nxt));

  assign last = (rom_addr == LAST);

  // Saturate the Q5.15 sum to Q1.15: in range only when the integer bits
  // and the sign bit all agree.
  always_comb begin
    acc_sum = acc + ACC_W'(term);
    acc_top = acc_sum[ACC_W-1:15];
    if ((&acc_top) || !(|acc_top)) begin
      result_nxt = acc_sum[15:0];
    end else begin
      result_nxt = acc_sum[ACC_W-1] ? Q_MIN : Q_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = TERM;
      TERM:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == INIT) || (state == TERM);
    done = (state == DONE);
  end

  // rom_addr doubles as the term counter k.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      pow      <= '0;
      acc      <= '0;
      rom_addr <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q      <= x_in;
            pow      <= x_in;
            acc      <= '0;
            rom_addr <= '0;
          end
        end
        TERM: begin
          acc      <= acc_sum;
          pow      <= pow_nxt;
          rom_addr <= last ? '0 : rom_addr + 1'b1;
          // Loaded from the final sum so result is already valid while done is high.
          if (last) result <= result_nxt;
        end
        DONE: rom_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_series_eval_ctrl.sv
// tb/tb_series_eval_ctrl.sv - directed self-checking bench for series_eval_ctrl
module tb_series_eval_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_in = 16'h0;

  logic [15:0] rom1 [8];
  logic [15:0] rom2 [8];
  logic [15:0] rom8 [8];
  logic [2:0]  a1, a2, a8;
  logic [15:0] rd1, rd2, rd8;
  logic        busy1, busy2, busy8, done1, done2, done8;
  logic [15:0] res1, res2, res8;

  int checks = 0;
  int errors = 0;

`ifdef ROUND_EN
  localparam logic [15:0] E_HALF   = 16'h4000;
  localparam logic [15:0] E_TWO    = 16'h3000;
`else
  localparam logic [15:0] E_HALF   = 16'h3FFF;
  localparam logic [15:0] E_TWO    = 16'h2FFF;
`endif

  assign rd1 = rom1[a1];
  assign rd2 = rom2[a2];
  assign rd8 = rom8[a8];

  series_eval_ctrl #(.TERMS(1), .ACC_W(20)) u_t1 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .rom_data(rd1),
    .rom_addr(a1), .busy(busy1), .done(done1), .result(res1));
  series_eval_ctrl #(.TERMS(2), .ACC_W(20)) u_t2 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .rom_data(rd2),
    .rom_addr(a2), .busy(busy2), .done(done2), .result(res2));
  series_eval_ctrl #(.TERMS(8), .ACC_W(20)) u_t8 (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .rom_data(rd8),
    .rom_addr(a8), .busy(busy8), .done(done8), .result(res8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one evaluation started at cycle 0; optional stray start (ig) or
  // reset (rc) at the given cycle. Reports first done cycle per instance.
  task automatic run(input logic [15:0] x, input int ig, input int rc,
                     output int d1, output int d2, output int d8, output int n8,
                     output logic b8c1, output logic b8c6,
                     output logic [2:0] a2c2, output logic [2:0] a2c3);
    d1 = -1; d2 = -1; d8 = -1; n8 = 0;
    b8c1 = 1'bx; b8c6 = 1'bx; a2c2 = 3'bx; a2c3 = 3'bx;
    start = 1'b1; x_in = x;
    tick();
    start = 1'b0; x_in = 16'h0;
    for (int c = 1; c <= 14; c++) begin
      if (done1 && d1 < 0) d1 = c;
      if (done2 && d2 < 0) d2 = c;
      if (done8 && d8 < 0) d8 = c;
      if (done8) n8++;
      if (c == 1) b8c1 = busy8;
      if (c == 6) b8c6 = busy8;
      if (c == 2) a2c2 = a2;
      if (c == 3) a2c3 = a2;
      start = (c == ig);
      x_in  = (c == ig) ? 16'h7FFF : 16'h0;
      rst   = (c == rc);
      tick();
    end
    start = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int d1, d2, d8, n8;
    logic b1, b6;
    logic [2:0] ac2, ac3;

    for (int i = 0; i < 8; i++) begin
      rom1[i] = 16'h0; rom2[i] = 16'h0; rom8[i] = 16'h7FFF;
    end

    // Reset held 3 cycles with a start pulse that must be ignored.
    rst = 1'b1; start = 1'b1; x_in = 16'h4000;
    tick(); tick(); tick();
    rst = 1'b0; start = 1'b0; x_in = 16'h0;
    chk("rst_busy",   32'(busy8),  32'd0);
    chk("rst_done",   32'(done8),  32'd0);
    chk("rst_result", 32'(res8),   32'd0);
    chk("rst_addr",   32'(a8),     32'd0);
    tick();
    chk("rst_idle_busy", 32'(busy8), 32'd0);
    chk("rst_idle_res1", 32'(res1),  32'd0);

    // One and two terms at x = 0.5.
    rom1[0] = 16'h7FFF;
    rom2[0] = 16'h7FFF; rom2[1] = 16'hC000;
    run(16'h4000, -1, -1, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("t1_done_cyc", 32'(d1),  32'd3);
    chk("t1_result",   32'(res1), 32'(E_HALF));
    chk("t2_done_cyc", 32'(d2),  32'd4);
    chk("t2_result",   32'(res2), 32'(E_TWO));
    chk("t2_addr_k0",  32'(ac2), 32'd0);
    chk("t2_addr_k1",  32'(ac3), 32'd1);
    chk("t8_done_cyc", 32'(d8),  32'd10);
    chk("t8_busy_c1",  32'(b1),  32'd1);
    chk("t8_one_pulse", 32'(n8), 32'd1);

    // x = 0 over eight terms, stray start at cycle 4 ignored.
    for (int i = 0; i < 8; i++) rom8[i] = 16'(16'h1111 * (i + 1));
    run(16'h0000, 4, -1, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("x0_done_cyc", 32'(d8),  32'd10);
    chk("x0_result",   32'(res8), 32'd0);
    chk("x0_one_pulse", 32'(n8), 32'd1);

    // x = -1: -0.5 * -1 and pow saturation at -1 * -1.
    rom1[0] = 16'hC000;
    rom2[0] = 16'h0000; rom2[1] = 16'h4000;
    run(16'h8000, -1, -1, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("neg1_result", 32'(res1), 32'h4000);
    chk("pow_sat",     32'(res2), 32'(E_HALF));

    // Accumulator beyond the Q1.15 range clamps both ways.
    for (int i = 0; i < 8; i++) rom8[i] = 16'h7FFF;
    run(16'h7FFF, -1, -1, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("sat_pos", 32'(res8), 32'h7FFF);
    for (int i = 0; i < 8; i++) rom8[i] = 16'h8000;
    run(16'h7FFF, -1, -1, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("sat_neg", 32'(res8), 32'h8000);

    // Reset during an eight-term run aborts it.
    run(16'h7FFF, -1, 5, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("abort_busy_c6", 32'(b6),  32'd0);
    chk("abort_no_done", 32'(n8),  32'd0);
    chk("abort_result",  32'(res8), 32'd0);

    // Normal operation resumes.
    for (int i = 0; i < 8; i++) rom8[i] = 16'h0;
    rom8[0] = 16'h7FFF;
    run(16'h4000, -1, -1, d1, d2, d8, n8, b1, b6, ac2, ac3);
    chk("resume_done_cyc", 32'(d8),  32'd10);
    chk("resume_result",   32'(res8), 32'(E_HALF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
